// File: rtl/fetch_pkg.sv
// Shared definitions for the burst fetch front end.
//   fetch_state_e : fetch FSM states
//   BURST_INCR    : AXI INCR burst encoding
//   RESP_OKAY     : AXI OKAY response encoding
//   INSTR_WIDTH   : instruction word width
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         INSTR_WIDTH = 32;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through FIFO with a multi-lane push port.
//   clk, reset   : clock, asynchronous active-low reset
//   flush        : synchronous clear of all entries (wins over push/pop)
//   push_en      : per-lane push enables; enabled lanes are written in lane order
//   push_data    : per-lane write data
//   pop          : remove the head entry (ignored when empty)
//   rd_data      : head entry, valid whenever empty is low
//   empty, count : occupancy status
module fetch_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 32,
  parameter int LANES = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [LANES-1:0]            push_en,
  input  logic [LANES-1:0][WIDTH-1:0] push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        empty,
  output logic [CW-1:0]               count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    n_push;
  logic [PW-1:0]    wr_addr [LANES];
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign pop_ok  = pop && !empty;

  // Enabled lanes are packed into consecutive slots, so each lane's slot is
  // the write pointer plus the number of enabled lanes below it.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_addr[i] = wr_ptr_q + n_push[PW-1:0];
      if (push_en[i]) n_push = n_push + CW'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
    rd_ptr_d = rd_ptr_q + (pop_ok ? PW'(1) : PW'(0));
    count_d  = count_q + n_push - {{(CW-1){1'b0}}, pop_ok};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en[i] && !flush) mem[wr_addr[i]] <= push_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_burst_fetch_buffer.sv
// Instruction-fetch front end: issues AXI4 INCR read bursts from the PC,
// unpacks each beat into 32-bit instructions, buffers them in a credit-managed
// FIFO and streams them out with their PC. Redirects flush the buffer and
// drop the rest of any in-flight burst.
//   clk, reset       : clock, asynchronous active-low reset (loads entry)
//   redirect_*       : single-cycle flush and restart at redirect_pc
//   m_axi_ar*/r*     : AXI4 read address / read data channels
//   instr_*          : valid/ready instruction stream with pc and bus error flag
//   fetch_busy       : a burst is outstanding
// Optional macro FETCH_PERF_CNT_EN adds perf_bursts, perf_discards and
// perf_stall saturating counters.
module axi_burst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_err,
  input  logic                  instr_ready,
  output logic                  fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_bursts,
  output logic [31:0]           perf_discards,
  output logic [31:0]           perf_stall
`endif
);

  localparam int IPB         = DATA_WIDTH / INSTR_WIDTH;
  localparam int SLOTS       = BURST_LEN * IPB;
  localparam int BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W     = 1 + ADDR_WIDTH + INSTR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] start_pc_q, start_pc_d;
  logic [ADDR_WIDTH-1:0] beat_pc_q, beat_pc_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CW-1:0]         reserved_q, reserved_d;
  logic                  pend_q, pend_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;

  logic [IPB-1:0]              push_en;
  logic [IPB-1:0][ENTRY_W-1:0] push_data;
  logic [IPB-1:0]              lane_keep;
  logic [ENTRY_W-1:0]          fifo_rd;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic [CW-1:0]               free_slots;
  logic                        credit_ok;
  logic                        beat_fire;
  logic                        unused_rid;

  assign unused_rid = ^m_axi_rid;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign fetch_busy    = (state_q != IDLE);

  // Slots already promised to the outstanding burst count against the FIFO,
  // so a burst is only requested when every one of its instructions fits.
  assign free_slots = CW'(FIFO_DEPTH) - fifo_count - reserved_q;
  assign credit_ok  = (free_slots >= CW'(SLOTS));
  assign beat_fire  = m_axi_rvalid && rready_q;

  // Lanes below the fetch PC (burst start was aligned down) are dropped.
  always_comb begin
    for (int i = 0; i < IPB; i++) begin
      logic [ADDR_WIDTH-1:0] lane_pc;
      lane_pc      = beat_pc_q + ADDR_WIDTH'(4 * i);
      lane_keep[i] = (lane_pc >= start_pc_q);
      push_data[i] = {(m_axi_rresp != RESP_OKAY), lane_pc,
                      m_axi_rdata[INSTR_WIDTH*i +: INSTR_WIDTH]};
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    start_pc_d = start_pc_q;
    beat_pc_d  = beat_pc_q;
    araddr_d   = araddr_q;
    reserved_d = reserved_q;
    pend_d     = pend_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    push_en    = '0;

    case (state_q)
      IDLE: begin
        // Never launch from a PC that is being replaced this cycle.
        if (credit_ok && !redirect_valid) begin
          state_d    = ADDR;
          arvalid_d  = 1'b1;
          araddr_d   = fetch_pc_q & ~ADDR_WIDTH'(BURST_BYTES - 1);
          start_pc_d = fetch_pc_q;
        end
      end
      ADDR: begin
        if (redirect_valid) pend_d = 1'b1;
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_pc_d = araddr_q;
          pend_d    = 1'b0;
          if (pend_q || redirect_valid) begin
            state_d    = DRAIN;
            reserved_d = '0;
          end else begin
            state_d    = DATA;
            reserved_d = CW'(SLOTS);
            fetch_pc_d = araddr_q + ADDR_WIDTH'(BURST_BYTES);
          end
        end
      end
      DATA: begin
        if (beat_fire) beat_pc_d = beat_pc_q + ADDR_WIDTH'(BEAT_BYTES);
        if (redirect_valid) begin
          reserved_d = '0;
          if (beat_fire && m_axi_rlast) begin
            state_d  = IDLE;
            rready_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (beat_fire) begin
          push_en    = lane_keep;
          reserved_d = reserved_q - CW'(IPB);
          if (m_axi_rlast) begin
            state_d    = IDLE;
            rready_d   = 1'b0;
            reserved_d = '0;
          end
        end
      end
      DRAIN: begin
        if (beat_fire && m_axi_rlast) begin
          state_d  = IDLE;
          rready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= entry;
      start_pc_q <= '0;
      beat_pc_q  <= '0;
      araddr_q   <= '0;
      reserved_q <= '0;
      pend_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      start_pc_q <= start_pc_d;
      beat_pc_q  <= beat_pc_d;
      araddr_q   <= araddr_d;
      reserved_q <= reserved_d;
      pend_q     <= pend_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .LANES (IPB)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push_en   (push_en),
    .push_data (push_data),
    .pop       (instr_ready),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_rd[INSTR_WIDTH-1:0];
  assign instr_pc    = fifo_rd[INSTR_WIDTH +: ADDR_WIDTH];
  assign instr_err   = fifo_rd[ENTRY_W-1];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bursts_q, bursts_d;
  logic [31:0] discards_q, discards_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_n;

  // Dropped lanes: misaligned lanes of a kept beat, or whole beats that are
  // discarded by a redirect or while draining.
  always_comb begin
    drop_n = '0;
    if (beat_fire) begin
      if (state_q == DRAIN || (state_q == DATA && redirect_valid)) begin
        drop_n = 32'(IPB);
      end else if (state_q == DATA) begin
        for (int i = 0; i < IPB; i++) drop_n = drop_n + {31'd0, !lane_keep[i]};
      end
    end
  end

  always_comb begin
    logic [32:0] sum;
    bursts_d = bursts_q;
    stall_d  = stall_q;
    if (state_q == ADDR && m_axi_arready && bursts_q != '1) bursts_d = bursts_q + 32'd1;
    if (state_q == IDLE && !credit_ok && stall_q != '1) stall_d = stall_q + 32'd1;
    sum        = {1'b0, discards_q} + {1'b0, drop_n};
    discards_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bursts_q   <= '0;
      discards_q <= '0;
      stall_q    <= '0;
    end else begin
      bursts_q   <= bursts_d;
      discards_q <= discards_d;
      stall_q    <= stall_d;
    end
  end

  assign perf_bursts   = bursts_q;
  assign perf_discards = discards_q;
  assign perf_stall    = stall_q;
`endif

endmodule

// File: doc/axi_burst_fetch_buffer.md
Name: axi_burst_fetch_buffer

Overview:
Parametrised instruction-fetch front end. Issues AXI4 INCR read bursts starting from the program counter and unpacks each data beat into 32-bit instructions. Buffers the instructions in a credit-managed FIFO and presents them as a valid/ready stream, each with its PC, to the IF/ID pipeline register. Supports redirect/flush with discard of in-flight bursts.

Parameters:
ID_WIDTH, 13, AXI ID width
ADDR_WIDTH, 64, address and PC width
DATA_WIDTH, 64, AXI data width; multiple of 32; IPB = DATA_WIDTH/32 instructions per beat
BURST_LEN, 8, beats per burst; BURST_LEN*DATA_WIDTH/8 is a power of two dividing 4096
FIFO_DEPTH, 32, instruction entries; power of two, >= BURST_LEN*IPB

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
entry  in  ADDR_WIDTH  PC loaded on reset
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_WIDTH  new PC; 4-byte aligned
m_axi_arid  out  ID_WIDTH  constant 0
m_axi_araddr  out  ADDR_WIDTH  burst start address
m_axi_arlen  out  8  constant BURST_LEN-1
m_axi_arsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  ID_WIDTH  ignored
m_axi_rdata  in  DATA_WIDTH  beat data
m_axi_rresp  in  2  beat response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
instr_valid  out  1  instruction available
instr  out  32  instruction word
instr_pc  out  ADDR_WIDTH  instruction address
instr_err  out  1  bus error on the fetch of this instruction
instr_ready  in  1  consumer accepts
fetch_busy  out  1  burst outstanding

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; fetch_pc=entry; FIFO empty; reserved=0; arvalid=0; rready=0; instr_valid=0; fetch_busy=0.
- Burst address: araddr = fetch_pc aligned down to BURST_BYTES. Instructions below fetch_pc within the burst are discarded, not pushed. After the burst, fetch_pc = aligned + BURST_BYTES.
- Credit: free = FIFO_DEPTH - count - reserved. AR is issued only when free >= BURST_LEN*IPB. reserved is set to BURST_LEN*IPB at the AR handshake and decremented for every pushed or discarded slot. Overflow is therefore impossible.
- IDLE: if credit is available, go to ADDR with arvalid=1 on the next cycle.
- ADDR: arvalid and araddr are held stable until arready. On handshake, go to DATA, or to DRAIN if a redirect arrived during ADDR. fetch_busy=1 from ADDR through the end of the burst.
- DATA: rready=1. Each beat pushes IPB instructions, low 32 bits first, with pc incrementing by 4. On rlast, go to IDLE.
- DRAIN: rready=1. Beats are dropped. On rlast, go to IDLE.
- rresp!=2'b00: all instructions of that beat are pushed with instr_err=1. The burst continues normally.
- Redirect (single-cycle pulse):
  - FIFO is flushed the same cycle.
  - fetch_pc=redirect_pc.
  - reserved is cleared once the current burst is abandoned.
  - DATA -> DRAIN.
  - A beat arriving in the redirect cycle is discarded.
  - If redirect and an instr handshake coincide, the redirect wins; the consumer treats its handshaken instruction as its own concern.
- FIFO: first-word fall-through; instr_valid = !empty; pop on instr_valid && instr_ready. Push and pop in the same cycle are allowed. Empty means instr_valid=0.
- Read returns arrive in order; a single burst is outstanding at a time.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_bursts (32 bits, AR handshakes), perf_discards (32 bits, dropped instructions, including misalignment and drain), and perf_stall (32 bits, cycles in IDLE without credit). Counters reset to 0 and saturate at all-ones. When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: state enum (IDLE, ADDR, DATA, DRAIN); AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00; INSTR_WIDTH=32.
- Sub-module fetch_fifo: parametrised width/depth with FWFT, a multi-push port of up to IPB entries with per-lane enable, single pop, synchronous flush, and a count output.

Test Plan:
- Reset, entry=0x8000_0000, defaults, instr_ready=1 -> araddr=0x8000_0000, arlen=7, arsize=3, arburst=1; 16 instructions out, pcs 0x8000_0000..0x8000_003C in order; next araddr=0x8000_0040.
- entry=0x8000_0008 -> araddr=0x8000_0000; first instr_pc=0x8000_0008; exactly 14 instructions from the burst.
- instr_ready=0 -> two bursts fill the FIFO (32 entries) and there is no third AR. Popping 15 gives no AR; popping the 16th gives arvalid on the next cycle.
- Redirect to 0x8000_1000 after beat 3 of 8 -> instr_valid=0 next cycle; beats 4-8 are accepted and dropped; next araddr=0x8000_1000 only after rlast.
- rresp=2'b10 on beat 2 -> instructions at pc+8 and pc+12 have instr_err=1, all others 0; the burst completes.
- Assert reset mid-burst with arready held low -> arvalid=0, instr_valid=0 immediately; after release, araddr restarts at entry.
